// File: rtl/pe_result_collector.sv
// PE result collector: bias add, rounding requantize with saturation, output FIFO.
// Optional ReLU clamp after saturation when PE_RESULT_RELU_EN is defined.
module pe_result_collector #(
  parameter int PE_OUT_WIDTH = 24,
  parameter int BIAS_WIDTH   = 16,
  parameter int SHIFT_WIDTH  = 5,
  parameter int OUT_WIDTH    = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [PE_OUT_WIDTH-1:0]       in_data,
  input  logic signed [BIAS_WIDTH-1:0]  cfg_bias,
  input  logic [SHIFT_WIDTH-1:0]        cfg_shift,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [OUT_WIDTH-1:0]   out_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int SW = PE_OUT_WIDTH + 2;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic signed [SW:0] MAXV =
    (SW+1)'(2**(OUT_WIDTH-1) - 1);
  localparam logic signed [SW:0] MINV =
    -((SW+1)'(2**(OUT_WIDTH-1)));

  logic                   s1_valid_q;
  logic signed [SW-1:0]   s1_sum_q;
  logic signed [SW-1:0]   s1_sum_d;
  logic [SHIFT_WIDTH-1:0] s1_shift_q;

  always_comb begin
    s1_sum_d = $signed({2'b00, in_data})
             + $signed({{(SW-BIAS_WIDTH){cfg_bias[BIAS_WIDTH-1]}},
                        cfg_bias});
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_sum_q   <= '0;
      s1_shift_q <= '0;
    end else begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_sum_q   <= s1_sum_d;
        s1_shift_q <= cfg_shift;
      end
    end
  end

  int                        sh;
  logic signed [SW:0]        ext;
  logic signed [SW:0]        half;
  logic signed [SW:0]        rnd;
  logic signed [SW:0]        shr;
  logic signed [OUT_WIDTH-1:0] q_d;

  // One extra bit on top of the sum so the rounding add cannot wrap.
  always_comb begin
    sh = int'(s1_shift_q);
    if (sh > SW - 1) sh = SW - 1;
    ext  = {s1_sum_q[SW-1], s1_sum_q};
    half = '0;
    if (sh != 0) half = (SW+1)'(1) << (sh - 1);
    rnd = ext + half;
    shr = rnd >>> sh;
    if (shr > MAXV)      q_d = MAXV[OUT_WIDTH-1:0];
    else if (shr < MINV) q_d = MINV[OUT_WIDTH-1:0];
    else                 q_d = shr[OUT_WIDTH-1:0];
`ifdef PE_RESULT_RELU_EN
    if (q_d[OUT_WIDTH-1]) q_d = '0;
`else
`endif
  end

  logic                 s2_valid_q;
  logic [OUT_WIDTH-1:0] s2_data_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) s2_data_q <= q_d;
    end
  end

  logic [OUT_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        count_q, count_d;
  logic                 ovf_q;
  logic                 full, empty, push, pop, drop;

  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign pop   = !empty && out_ready;
  assign push  = s2_valid_q && (!full || pop);
  assign drop  = s2_valid_q && full && !pop;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      if (drop) ovf_q <= 1'b1;
    end
  end

  // Storage is masked by the count, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= s2_data_q;
  end

  assign out_valid  = !empty;
  assign out_data   = empty ? '0 : mem_q[rd_ptr_q];
  assign fifo_count = count_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_pe_result_collector.sv
// Self-checking bench for pe_result_collector against a queue-based model.
// Honors PE_RESULT_RELU_EN for expected output values.
module tb_pe_result_collector;

  localparam int PW = 24;
  localparam int BW = 16;
  localparam int SHW = 5;
  localparam int OW = 8;
  localparam int DEPTH = 4;
  localparam longint OMAX = 127;
  localparam longint OMIN = -128;

  logic                 clk;
  logic                 reset;
  logic                 in_valid;
  logic [PW-1:0]        in_data;
  logic signed [BW-1:0] cfg_bias;
  logic [SHW-1:0]       cfg_shift;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [OW-1:0] out_data;
  logic [2:0]           fifo_count;
  logic                 overflow;

  int checks = 0;
  int errors = 0;

  int mq[$];
  int pd_due[$];
  int pd_val[$];
  bit m_ovf = 0;
  int ecount = 0;

  pe_result_collector #(
    .PE_OUT_WIDTH(PW), .BIAS_WIDTH(BW), .SHIFT_WIDTH(SHW),
    .OUT_WIDTH(OW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data),
    .cfg_bias(cfg_bias), .cfg_shift(cfg_shift),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .fifo_count(fifo_count),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ref_q(longint d, longint b, int s);
    longint sum, p, r;
    int se;
    sum = d + b;
    se = (s > PW + 1) ? PW + 1 : s;
    if (se == 0) r = sum;
    else begin
      p = longint'(1) << se;
      r = sum + p / 2;
      if (r >= 0) r = r / p;
      else r = -((-r + p - 1) / p);
    end
    if (r > OMAX) r = OMAX;
    if (r < OMIN) r = OMIN;
`ifdef PE_RESULT_RELU_EN
    if (r < 0) r = 0;
`endif
    return int'(r);
  endfunction

  function automatic int m_head();
    return (mq.size() != 0) ? mq[0] : 0;
  endfunction

  task automatic step();
    bit pop, push, full;
    int nv;
    pop  = (mq.size() != 0) && (out_ready === 1'b1);
    full = (mq.size() == DEPTH);
    push = (pd_due.size() != 0) && (pd_due[0] == ecount);
    nv = ref_q(longint'(in_data), longint'(cfg_bias), int'(cfg_shift));
    @(posedge clk);
    if (pop) void'(mq.pop_front());
    if (push) begin
      if (full && !pop) m_ovf = 1'b1;
      else mq.push_back(pd_val[0]);
      void'(pd_due.pop_front());
      void'(pd_val.pop_front());
    end
    if (in_valid) begin
      pd_due.push_back(ecount + 2);
      pd_val.push_back(nv);
    end
    ecount++;
    #1;
  endtask

  task automatic apply_reset();
    in_valid = 1'b0;
    reset = 1'b0;
    mq.delete();
    pd_due.delete();
    pd_val.delete();
    m_ovf = 1'b0;
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    out_ready = 1'b0;
    in_data = '0;
    cfg_bias = '0;
    cfg_shift = '0;
    apply_reset();
    repeat (2) @(posedge clk);
    #1;
    checks += 4;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got %b want 0", out_valid);
    end
    if (out_data !== 8'sd0) begin
      errors++; $display("FAIL reset_data got %0d want 0", out_data);
    end
    if (fifo_count !== 3'd0) begin
      errors++; $display("FAIL reset_count got %0d want 0", fifo_count);
    end
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL reset_ovf got %b want 0", overflow);
    end
    release_reset();
  endtask

  task automatic test_basic();
    bit ev;
    out_ready = 1'b1;
    in_data = PW'(1000);
    cfg_bias = '0;
    cfg_shift = 5'd3;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    cfg_shift = 5'd0;
    cfg_bias = 16'sd100;
    for (int k = 1; k <= 4; k++) begin
      ev = (k == 3);
      checks += 2;
      if (out_valid !== ev) begin
        errors++;
        $display("FAIL basic_valid edge=%0d got %b want %b", k, out_valid, ev);
      end
      if (out_data !== OW'(m_head())) begin
        errors++;
        $display("FAIL basic_model edge=%0d got %0d want %0d", k, out_data, m_head());
      end
      if (k == 3) begin
        checks++;
        if (out_data !== 8'sd125) begin
          errors++; $display("FAIL basic_data got %0d want 125", out_data);
        end
      end
      if (k < 4) step();
    end
  endtask

  task automatic test_saturation();
    int vd[5] = '{100, 5000, 6, 5, 4};
    int vb[5] = '{-300, 0, 0, 0, -7};
    int vs[5] = '{0, 2, 2, 2, 1};
`ifdef PE_RESULT_RELU_EN
    int ve[5] = '{0, 127, 2, 1, 0};
`else
    int ve[5] = '{-128, 127, 2, 1, -1};
`endif
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = PW'(vd[i]);
      cfg_bias = BW'(vb[i]);
      cfg_shift = SHW'(vs[i]);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      step();
      checks += 3;
      if (out_valid !== 1'b1) begin
        errors++; $display("FAIL sat_valid vec=%0d got %b want 1", i, out_valid);
      end
      if (out_data !== OW'(ve[i])) begin
        errors++; $display("FAIL sat_data vec=%0d got %0d want %0d", i, out_data, ve[i]);
      end
      if (out_data !== OW'(m_head())) begin
        errors++; $display("FAIL sat_model vec=%0d got %0d want %0d", i, out_data, m_head());
      end
      step();
    end
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    cfg_bias = '0;
    cfg_shift = '0;
    for (int i = 1; i <= 5; i++) begin
      in_data = PW'(i);
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();
    checks += 2;
    if (fifo_count !== 3'd4) begin
      errors++; $display("FAIL ovf_count got %0d want 4", fifo_count);
    end
    if (overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_flag got %b want 1", overflow);
    end
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checks += 2;
      if (out_data !== OW'(i)) begin
        errors++; $display("FAIL ovf_order i=%0d got %0d want %0d", i, out_data, i);
      end
      if (fifo_count !== 3'(5 - i)) begin
        errors++; $display("FAIL ovf_drain i=%0d got %0d want %0d", i, fifo_count, 5 - i);
      end
      step();
    end
    checks += 3;
    if (fifo_count !== 3'd0) begin
      errors++; $display("FAIL ovf_empty got %0d want 0", fifo_count);
    end
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL ovf_valid got %b want 0", out_valid);
    end
    if (overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_sticky got %b want 1", overflow);
    end
  endtask

  task automatic test_full_pushpop();
    apply_reset();
    release_reset();
    out_ready = 1'b0;
    cfg_bias = '0;
    cfg_shift = '0;
    for (int i = 1; i <= 5; i++) begin
      in_data = PW'(10 * i);
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (fifo_count !== 3'd4) begin
      errors++; $display("FAIL pp_full got %0d want 4", fifo_count);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks += 3;
    if (fifo_count !== 3'd4) begin
      errors++; $display("FAIL pp_count got %0d want 4", fifo_count);
    end
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL pp_ovf got %b want 0", overflow);
    end
    if (out_data !== 8'sd20) begin
      errors++; $display("FAIL pp_head got %0d want 20", out_data);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_data !== OW'(20 + 10 * i)) begin
        errors++;
        $display("FAIL pp_order i=%0d got %0d want %0d", i, out_data, 20 + 10 * i);
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    cfg_bias = '0;
    cfg_shift = '0;
    for (int i = 1; i <= 5; i++) begin
      in_data = PW'(i);
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();
    in_data = PW'(77);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    checks++;
    if (fifo_count !== 3'd4 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL rm_pre count=%0d ovf=%b want 4/1", fifo_count, overflow);
    end
    apply_reset();
    #1;
    checks += 4;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL rm_valid got %b want 0", out_valid);
    end
    if (fifo_count !== 3'd0) begin
      errors++; $display("FAIL rm_count got %0d want 0", fifo_count);
    end
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL rm_ovf got %b want 0", overflow);
    end
    if (out_data !== 8'sd0) begin
      errors++; $display("FAIL rm_data got %0d want 0", out_data);
    end
    release_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      checks++;
      if (out_valid !== 1'b0 || fifo_count !== 3'd0) begin
        errors++;
        $display("FAIL rm_stale cyc=%0d valid=%b count=%0d want 0/0", k, out_valid, fifo_count);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 700; c++) begin
      if (c < 640) begin
        in_valid  = ($urandom % 3) != 0;
        in_data   = ($urandom % 2) ? PW'($urandom) : PW'($urandom_range(0, 3000));
        cfg_bias  = BW'($urandom);
        cfg_shift = SHW'($urandom);
        out_ready = ($urandom % 4) != 0;
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      step();
      checks += 4;
      if (out_valid !== (mq.size() != 0)) begin
        errors++; $display("FAIL rnd_valid cyc=%0d got %b want %b", c, out_valid, mq.size() != 0);
      end
      if (out_data !== OW'(m_head())) begin
        errors++; $display("FAIL rnd_data cyc=%0d got %0d want %0d", c, out_data, m_head());
      end
      if (fifo_count !== 3'(mq.size())) begin
        errors++; $display("FAIL rnd_count cyc=%0d got %0d want %0d", c, fifo_count, mq.size());
      end
      if (overflow !== m_ovf) begin
        errors++; $display("FAIL rnd_ovf cyc=%0d got %b want %b", c, overflow, m_ovf);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_data = '0;
    cfg_bias = '0;
    cfg_shift = '0;
    test_reset();
    test_basic();
    test_saturation();
    test_overflow();
    test_full_pushpop();
    test_reset_mid();
    apply_reset();
    release_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
